csa: RTL and testbench

//   Registered carry-select adder: sum/cout = a + b + cin.

---
 rtl/csa.sv | 76 +++++++
 tb/tb_csa.sv | 111 +++++++++++
 2 files changed

// File: rtl/csa.sv
// Registered carry-select adder: {cout,sum} = a + b + cin, one-cycle latency.
// Block 0 ripples from cin; higher blocks precompute both carry-in cases and mux.
module csa_rca #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         c,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W:0] cy;

  assign cy[0] = c;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]    = x[i] ^ y[i] ^ cy[i];
    assign cy[i+1] = (x[i] & y[i]) | (cy[i] & (x[i] ^ y[i]));
  end
  assign co = cy[W];
endmodule

module csa #(
  parameter int WIDTH = 8,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NBLK = (WIDTH + BLOCK - 1) / BLOCK;

  logic [NBLK:0]    bc;
  logic [WIDTH-1:0] s_nx;

  assign bc[0] = cin;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    localparam int LO = k * BLOCK;
    // top block absorbs the remainder when WIDTH is not a multiple of BLOCK
    localparam int HI = (LO + BLOCK > WIDTH) ? WIDTH - 1 : LO + BLOCK - 1;
    localparam int W  = HI - LO + 1;

    if (k == 0) begin : g_lo
      csa_rca #(.W(W)) u_rca (
        .x(a[HI:LO]), .y(b[HI:LO]), .c(bc[0]), .s(s_nx[HI:LO]), .co(bc[1])
      );
    end else begin : g_sel
      logic [W-1:0] s0, s1;
      logic         c0, c1;

      csa_rca #(.W(W)) u_rca0 (
        .x(a[HI:LO]), .y(b[HI:LO]), .c(1'b0), .s(s0), .co(c0)
      );
      csa_rca #(.W(W)) u_rca1 (
        .x(a[HI:LO]), .y(b[HI:LO]), .c(1'b1), .s(s1), .co(c1)
      );

      assign s_nx[HI:LO] = bc[k] ? s1 : s0;
      assign bc[k+1]     = bc[k] ? c1 : c0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= s_nx;
      cout <= bc[NBLK];
    end
  end
endmodule

// File: tb/tb_csa.sv
// Scoreboard bench for csa: driver pushes hand-computed {cout,sum}, monitor pops and compares.
module tb_csa;
  logic       clk;
  logic       rst_n;
  logic [7:0] a, b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;

  int tests, fails;
  logic [8:0] exp_q[$];

  csa #(.WIDTH(8), .BLOCK(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, got %0d tests, required completion", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got cout,sum=%h required %h", name, act, exp);
    end
  endtask

  // Monitor: every edge taken out of reset with a pending expectation is checked.
  always @(posedge clk) begin
    logic [8:0] e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      #1;
      check("sb", {cout, sum}, e);
    end
  end

  task automatic drive(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                       input logic [8:0] e);
    @(negedge clk);
    a = va; b = vb; cin = vc;
    exp_q.push_back(e);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b1; a = 8'd6; b = 8'd6; cin = 1'b0;

    // 1: async reset before any clock edge, then held with toggling operands
    #1 rst_n = 1'b0;
    #1 check("rst_async", {cout, sum}, 9'h000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = (i % 2) ? 8'd6 : 8'd9;
      b = (i % 2) ? 8'd6 : 8'd3;
      #2 check("rst_hold", {cout, sum}, 9'h000);
    end

    // release at a negedge; first capture on the following posedge
    @(negedge clk);
    rst_n = 1'b1;
    a = 8'd6; b = 8'd6; cin = 1'b0;
    exp_q.push_back(9'd12);

    // 2..5 directed
    drive(8'd6,  8'd7,  1'b0, 9'd13);
    drive(8'h0F, 8'h01, 1'b0, 9'h010);
    drive(8'hFF, 8'h01, 1'b0, 9'h100);
    drive(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    drive(8'h00, 8'h00, 1'b1, 9'h001);
    drive(8'h80, 8'h7F, 1'b1, 9'h100);

    // 6: back-to-back vectors with a mid-stream reset pulse
    drive(8'h3C, 8'hA5, 1'b0, 9'h0E1);
    drive(8'h80, 8'h80, 1'b1, 9'h101);
    drive(8'h7F, 8'h00, 1'b1, 9'h080);
    drive(8'h55, 8'hAA, 1'b1, 9'h100);

    // in-flight vector discarded by reset asserted before its capture edge
    @(negedge clk);
    a = 8'h77; b = 8'h11; cin = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("rst_mid", {cout, sum}, 9'h000);
    @(negedge clk);
    check("rst_discard", {cout, sum}, 9'h000);
    a = 8'hFF; b = 8'hFF; cin = 1'b1;
    @(negedge clk);
    check("rst_hold2", {cout, sum}, 9'h000);

    rst_n = 1'b1;
    a = 8'h12; b = 8'h34; cin = 1'b0;
    exp_q.push_back(9'h046);
    drive(8'hF0, 8'h0F, 1'b1, 9'h100);
    drive(8'hC8, 8'h64, 1'b0, 9'h12C);
    drive(8'h01, 8'hFE, 1'b0, 9'h0FF);

    @(negedge clk);
    @(negedge clk);
    check("sb_drained", 9'(exp_q.size()), 9'd0);
    check("hold_last", {cout, sum}, 9'h0FF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
